// File: rtl/bus_timer_slave.sv
// bus_timer_slave: memory-mapped interval timer answering the req/as_/rw/rdy_
// bus handshake after WAIT_CYCLES wait states.
// Register map: 0 CTRL (start, periodic), 1 INTR (irq flag), 2 EXPR, 3 COUNTER.
// Build option: define TIMER_PRESCALE_EN to add an 8-bit prescaler in CTRL[15:8].
module bus_timer_slave #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Value of the wait counter on the last WAIT cycle.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state_reg;
    logic [3:0]        wait_cnt_reg;
    logic [1:0]        lat_addr_reg;
    logic              lat_rw_reg;
    logic [31:0]       lat_data_reg;
    logic [31:0]       rd_data_reg;
    logic              rdy_reg;

    logic              start_reg, start_next;
    logic              periodic_reg, periodic_next;
    logic              flag_reg, flag_next;
    logic [CNT_W-1:0]  expr_reg, expr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

`ifdef TIMER_PRESCALE_EN
    logic [7:0]        ps_reg, ps_next;
    logic [7:0]        ps_cnt_reg, ps_cnt_next;
`endif

    logic              accept;
    logic              enter_resp;
    logic [1:0]        txn_addr;
    logic              txn_rw;
    logic [31:0]       txn_data;
    logic              wr_ctrl, wr_intr, wr_expr, wr_cnt;
    logic              step, match, timer_set;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign accept = (state_reg == IDLE) && !cs_ && !as_;

    // With no wait states the accepting edge is also the commit edge, so the
    // live bus fields are used directly; otherwise the latched copies are.
    assign txn_addr = (state_reg == IDLE) ? addr    : lat_addr_reg;
    assign txn_rw   = (state_reg == IDLE) ? rw      : lat_rw_reg;
    assign txn_data = (state_reg == IDLE) ? wr_data : lat_data_reg;
    assign unused_bits = ^txn_data;

    // Decide whether this edge moves the bus FSM into RESP.
    always_comb begin
        enter_resp = 1'b0;
        if (state_reg == IDLE) begin
            enter_resp = accept && (WAIT_CYCLES == 0);
        end else if (state_reg == WAIT) begin
            enter_resp = (wait_cnt_reg == WAIT_LAST);
        end
    end

    assign wr_ctrl = enter_resp && !txn_rw && (txn_addr == 2'd0);
    assign wr_intr = enter_resp && !txn_rw && (txn_addr == 2'd1);
    assign wr_expr = enter_resp && !txn_rw && (txn_addr == 2'd2);
    assign wr_cnt  = enter_resp && !txn_rw && (txn_addr == 2'd3);

`ifdef TIMER_PRESCALE_EN
    assign step = start_reg && (ps_cnt_reg == ps_reg);
`else
    assign step = start_reg;
`endif
    assign match     = (cnt_reg == expr_reg);
    assign timer_set = step && match;

    // Timer step first, then bus writes override CTRL/COUNTER; a timer set of
    // the flag wins over a bus clear so no interrupt is lost.
    always_comb begin
        start_next    = start_reg;
        periodic_next = periodic_reg;
        flag_next     = flag_reg;
        expr_next     = expr_reg;
        cnt_next      = cnt_reg;
        if (step) begin
            if (match) begin
                cnt_next  = '0;
                flag_next = 1'b1;
                if (!periodic_reg) begin
                    start_next = 1'b0;
                end
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
        if (wr_ctrl) begin
            start_next    = txn_data[0];
            periodic_next = txn_data[1];
        end
        if (wr_intr && !txn_data[0]) begin
            flag_next = timer_set;
        end
        if (wr_expr) begin
            expr_next = txn_data[CNT_W-1:0];
        end
        if (wr_cnt) begin
            cnt_next = txn_data[CNT_W-1:0];
        end
    end

`ifdef TIMER_PRESCALE_EN
    // Prescale counter: restarts when stopped or when CTRL is written.
    always_comb begin
        ps_next     = ps_reg;
        ps_cnt_next = ps_cnt_reg;
        if (!start_reg || (ps_cnt_reg == ps_reg)) begin
            ps_cnt_next = 8'd0;
        end else begin
            ps_cnt_next = ps_cnt_reg + 8'd1;
        end
        if (wr_ctrl) begin
            ps_next     = txn_data[15:8];
            ps_cnt_next = 8'd0;
        end
    end
`endif

    // Read mux over the post-edge register values so a response shows any
    // same-cycle write or timer update.
    always_comb begin
        rd_word = '0;
        case (txn_addr)
            2'd0: begin
                rd_word[0] = start_next;
                rd_word[1] = periodic_next;
`ifdef TIMER_PRESCALE_EN
                rd_word[15:8] = ps_next;
`endif
            end
            2'd1: rd_word[0] = flag_next;
            2'd2: rd_word[CNT_W-1:0] = expr_next;
            default: rd_word[CNT_W-1:0] = cnt_next;
        endcase
    end

    // Bus FSM with registered rdy_/rd_data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            lat_addr_reg <= 2'd0;
            lat_rw_reg   <= 1'b0;
            lat_data_reg <= 32'd0;
            rdy_reg      <= 1'b1;
            rd_data_reg  <= 32'd0;
        end else begin
            rdy_reg     <= 1'b1;
            rd_data_reg <= 32'd0;
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        lat_addr_reg <= addr;
                        lat_rw_reg   <= rw;
                        lat_data_reg <= wr_data;
                        wait_cnt_reg <= 4'd0;
                        state_reg    <= enter_resp ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (enter_resp) begin
                        state_reg <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                RESP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (enter_resp) begin
                rdy_reg     <= 1'b0;
                rd_data_reg <= rd_word;
            end
        end
    end

    // Timer and register file state.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_reg    <= 1'b0;
            periodic_reg <= 1'b0;
            flag_reg     <= 1'b0;
            expr_reg     <= '0;
            cnt_reg      <= '0;
`ifdef TIMER_PRESCALE_EN
            ps_reg       <= 8'd0;
            ps_cnt_reg   <= 8'd0;
`endif
        end else begin
            start_reg    <= start_next;
            periodic_reg <= periodic_next;
            flag_reg     <= flag_next;
            expr_reg     <= expr_next;
            cnt_reg      <= cnt_next;
`ifdef TIMER_PRESCALE_EN
            ps_reg       <= ps_next;
            ps_cnt_reg   <= ps_cnt_next;
`endif
        end
    end

    assign rd_data = rd_data_reg;
    assign rdy_    = rdy_reg;
    assign irq     = flag_reg;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Testbench for bus_timer_slave: two instances (no wait states / 8-bit counter,
// and three wait states / 32-bit counter) checked every cycle against a
// behavioural model, plus directed scenario checks.
module tb_bus_timer_slave;

    localparam int NI = 2;

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs0_ = 1'b1, cs1_ = 1'b1, as_ = 1'b1, rw = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data0, rd_data1;
    logic        rdy0_, rdy1_, irq0, irq1;

    always #5 clk = ~clk;

    bus_timer_slave #(.WAIT_CYCLES(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .cs_(cs0_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data0), .rdy_(rdy0_), .irq(irq0));

    bus_timer_slave #(.WAIT_CYCLES(3), .CNT_W(32)) u_dut1 (
        .clk(clk), .reset(reset), .cs_(cs1_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data1), .rdy_(rdy1_), .irq(irq1));

`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_0003;
`endif

    // Reference model state per instance.
    logic [31:0] m_ctrl [NI] = '{0, 0};
    logic [31:0] m_cnt  [NI] = '{0, 0};
    logic [31:0] m_expr [NI] = '{0, 0};
    bit          m_flag [NI] = '{0, 0};
    int          m_ps   [NI] = '{0, 0};
    int          m_phase[NI] = '{0, 0};  // 0 idle, 1 waiting, 2 responding
    int          m_left [NI] = '{0, 0};
    bit          m_rw   [NI] = '{0, 0};
    logic [1:0]  m_addr [NI] = '{0, 0};
    logic [31:0] m_wd   [NI] = '{0, 0};
    bit          e_rdy  [NI] = '{1, 1};
    logic [31:0] e_rd   [NI] = '{0, 0};

    function automatic int wc(int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] cmask(int i);
        return (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the specified behaviour to instance i.
    task automatic model_edge(int i, logic cs);
        logic [31:0] nctrl, ncnt, nexpr;
        bit          nflag, step, tset, commit;
        int          nps;
        if (reset) begin
            m_ctrl[i] = 0; m_cnt[i] = 0; m_expr[i] = 0; m_flag[i] = 0; m_ps[i] = 0;
            m_phase[i] = 0; m_left[i] = 0; e_rdy[i] = 1; e_rd[i] = 0;
            return;
        end
        nctrl = m_ctrl[i]; ncnt = m_cnt[i]; nexpr = m_expr[i];
        nflag = m_flag[i]; nps = m_ps[i];
        step = 0; tset = 0; commit = 0;
        if (m_ctrl[i][0]) begin
`ifdef TIMER_PRESCALE_EN
            if (m_ps[i] == int'(m_ctrl[i][15:8])) begin
                nps = 0;
                step = 1;
            end else begin
                nps = m_ps[i] + 1;
            end
`else
            step = 1;
`endif
        end else begin
            nps = 0;
        end
        if (step) begin
            if (m_cnt[i] == m_expr[i]) begin
                ncnt = 0; nflag = 1; tset = 1;
                if (!m_ctrl[i][1]) nctrl[0] = 1'b0;
            end else begin
                ncnt = (m_cnt[i] + 1) & cmask(i);
            end
        end
        e_rdy[i] = 1; e_rd[i] = 0;
        case (m_phase[i])
            0: if (!cs && !as_) begin
                m_rw[i] = rw; m_addr[i] = addr; m_wd[i] = wr_data;
                if (wc(i) == 0) commit = 1;
                else begin m_phase[i] = 1; m_left[i] = wc(i); end
            end
            1: begin
                m_left[i]--;
                if (m_left[i] == 0) commit = 1;
            end
            default: m_phase[i] = 0;
        endcase
        if (commit) begin
            m_phase[i] = 2;
            if (!m_rw[i]) begin
                case (m_addr[i])
                    2'd0: begin nctrl = m_wd[i] & CTRL_MASK; nps = 0; end
                    2'd1: if (!m_wd[i][0] && !tset) nflag = 0;
                    2'd2: nexpr = m_wd[i] & cmask(i);
                    default: ncnt = m_wd[i] & cmask(i);
                endcase
            end
            e_rdy[i] = 0;
            case (m_addr[i])
                2'd0: e_rd[i] = nctrl;
                2'd1: e_rd[i] = {31'd0, nflag};
                2'd2: e_rd[i] = nexpr;
                default: e_rd[i] = ncnt;
            endcase
        end
        m_ctrl[i] = nctrl; m_cnt[i] = ncnt; m_expr[i] = nexpr;
        m_flag[i] = nflag; m_ps[i] = nps;
    endtask

    // One clock: advance the model at the edge, compare outputs mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge(0, cs0_);
        model_edge(1, cs1_);
        @(negedge clk);
        check("rdy0", 32'(rdy0_), 32'(e_rdy[0]));
        check("rd0", rd_data0, e_rd[0]);
        check("irq0", 32'(irq0), 32'(m_flag[0]));
        check("rdy1", 32'(rdy1_), 32'(e_rdy[1]));
        check("rd1", rd_data1, e_rd[1]);
        check("irq1", 32'(irq1), 32'(m_flag[1]));
    endtask

    // One bus transaction; optionally keeps strobing during the wait states.
    task automatic txn(int i, bit wr, logic [1:0] a, logic [31:0] d, bit poke,
                       output logic [31:0] rd);
        int lat;
        bit got;
        rw = !wr; addr = a; wr_data = d; as_ = 1'b0;
        if (i == 0) cs0_ = 1'b0; else cs1_ = 1'b0;
        tick();
        as_ = 1'b1; cs0_ = 1'b1; cs1_ = 1'b1;
        lat = 1;
        got = (i == 0) ? !rdy0_ : !rdy1_;
        while (!got && lat < 20) begin
            if (poke) begin
                as_ = 1'b0;
                if (i == 0) cs0_ = 1'b0; else cs1_ = 1'b0;
            end
            tick();
            as_ = 1'b1; cs0_ = 1'b1; cs1_ = 1'b1;
            lat++;
            got = (i == 0) ? !rdy0_ : !rdy1_;
        end
        check((i == 0) ? "latency0" : "latency1", lat, wc(i) + 1);
        rd = (i == 0) ? rd_data0 : rd_data1;
        tick();
    endtask

    task automatic wr_reg(int i, logic [1:0] a, logic [31:0] d);
        logic [31:0] dummy;
        txn(i, 1'b1, a, d, 1'b0, dummy);
    endtask

    // Ticks (counted from the commit edge) until irq of instance i is high.
    task automatic ticks_to_irq(int i, output int n);
        n = 1;
        while (((i == 0) ? !irq0 : !irq1) && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [31:0] v;
        int n;
        int ri, ra;

        // Reset and idle outputs.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_rdy1", 32'(rdy1_), 32'd1);

        // Every register reads 0 after reset on both instances.
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 4; a++) begin
                txn(i, 1'b0, 2'(a), 32'd0, 1'b0, v);
                check("rst_read", v, 32'd0);
            end
        end

        // Wait-state instance: write then read EXPR with as_ strobes during WAIT.
        txn(1, 1'b1, 2'd2, 32'h10, 1'b1, v);
        txn(1, 1'b0, 2'd2, 32'd0, 1'b1, v);
        check("expr_readback", v, 32'h10);

        // One-shot: irq 6 steps after start, then timer stopped at 0.
        wr_reg(1, 2'd2, 32'd5);
        wr_reg(1, 2'd0, 32'h1);
        ticks_to_irq(1, n);
        check("oneshot_delay", n, 32'd6);
        txn(1, 1'b0, 2'd3, 32'd0, 1'b0, v);
        check("oneshot_cnt", v, 32'd0);
        txn(1, 1'b0, 2'd0, 32'd0, 1'b0, v);
        check("oneshot_ctrl", v, 32'd0);
        wr_reg(1, 2'd1, 32'h1);
        check("intr_w1_keeps", 32'(irq1), 32'd1);
        wr_reg(1, 2'd1, 32'h0);
        check("intr_w0_clears", 32'(irq1), 32'd0);

        // Periodic on the 8-bit instance; back-to-back clears hit match edges.
        wr_reg(0, 2'd2, 32'd3);
        wr_reg(0, 2'd0, 32'h3);
        ticks_to_irq(0, n);
        check("periodic_delay", n, 32'd4);
        for (int k = 0; k < 12; k++) begin
            wr_reg(0, 2'd1, 32'h0);
            if (k == 5) tick();
        end
        wr_reg(0, 2'd0, 32'h0);
        wr_reg(0, 2'd1, 32'h0);
        check("periodic_stopped_irq", 32'(irq0), 32'd0);

        // Bus write to COUNTER beats the same-edge increment.
        wr_reg(1, 2'd2, 32'h1000);
        wr_reg(1, 2'd0, 32'h1);
        wr_reg(1, 2'd3, 32'h100);
        txn(1, 1'b0, 2'd3, 32'd0, 1'b0, v);
        check("collision_cnt", v, 32'h105);
        wr_reg(1, 2'd0, 32'h0);

        // 8-bit counter masks writes and wraps.
        wr_reg(0, 2'd2, 32'd5);
        wr_reg(0, 2'd0, 32'h1);
        wr_reg(0, 2'd3, 32'h1FE);
        txn(0, 1'b0, 2'd3, 32'd0, 1'b0, v);
        check("wrap_cnt", v, 32'h0);
        wr_reg(0, 2'd0, 32'h0);
        wr_reg(0, 2'd1, 32'h0);

        // Prescale field: readback and irq delay.
        wr_reg(0, 2'd3, 32'h0);
        wr_reg(0, 2'd2, 32'h50);
        wr_reg(0, 2'd0, 32'h0301);
        txn(0, 1'b0, 2'd0, 32'd0, 1'b0, v);
`ifdef TIMER_PRESCALE_EN
        check("ctrl_ps_read", v, 32'h0301);
`else
        check("ctrl_ps_read", v, 32'h0001);
`endif
        wr_reg(0, 2'd0, 32'h0);
        wr_reg(0, 2'd3, 32'h0);
        wr_reg(0, 2'd2, 32'd2);
        wr_reg(0, 2'd0, 32'h0301);
        ticks_to_irq(0, n);
`ifdef TIMER_PRESCALE_EN
        check("prescale_delay", n, 32'd12);
`else
        check("prescale_delay", n, 32'd3);
`endif

        // Randomised traffic checked cycle by cycle against the model.
        for (int k = 0; k < 80; k++) begin
            ri = int'($urandom_range(0, 1));
            ra = int'($urandom_range(0, 3));
            v = $urandom();
            case (ra)
                0: v = v & 32'hFFFF_0303;
                2: v = $urandom_range(0, 9);
                3: v = (ri == 1) ? 32'($urandom_range(0, 12)) : v;
                default: ;
            endcase
            txn(ri, 1'($urandom_range(0, 1)), 2'(ra), v, 1'($urandom_range(0, 1)), v);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset during WAIT aborts the write and clears everything.
        wr_reg(1, 2'd0, 32'h1);
        rw = 1'b0; addr = 2'd2; wr_data = 32'h55; as_ = 1'b0; cs1_ = 1'b0;
        tick();
        as_ = 1'b1; cs1_ = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("reset_in_wait_rdy", 32'(rdy1_), 32'd1);
        reset = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 4; a++) begin
                txn(i, 1'b0, 2'(a), 32'd0, 1'b0, v);
                check("post_reset_read", v, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_timer_slave.md
Name: bus_timer_slave

Overview:
- Memory-mapped interval timer that acts as a bus responder (slave) on the system bus; it is the target end of the req_/as_/rw/rdy_ handshake that the CPU's IF and MEM bus masters initiate.
- Decodes a 2-bit word offset and answers reads and writes after a programmable number of wait states.
- Counts toward a programmed expire value and raises a level interrupt that feeds one bit of cpu_irq.

Parameters:
- WAIT_CYCLES, 0, wait states inserted between request acceptance and rdy_ assertion (legal range 0..15).
- CNT_W, 32, counter/expire register width (≤32); upper bits read as 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs_  in  1  chip select from the bus address decoder, active low.
- as_  in  1  address strobe, active low.
- rw  in  1  1 = read, 0 = write.
- addr  in  2  word offset (bus word address bits [1:0]).
- wr_data  in  32  write data.
- rd_data  out  32  read data; 0 whenever rdy_=1.
- rdy_  out  1  ready, active low, one-cycle pulse.
- irq  out  1  timer interrupt, level, active high.

Behaviour:
- Register map:
  - 0 CTRL: bit0 = start, bit1 = periodic.
  - 1 INTR: bit0 = irq flag; a write with bit0=0 clears the flag, a write with bit0=1 is ignored.
  - 2 EXPR: expire value.
  - 3 COUNTER: current count; read/write.
  - All unused bits read 0.
- Reset (synchronous, reset=1 at the clk edge):
  - All registers = 0; irq=0, rdy_=1, rd_data=0, FSM = IDLE, wait counter = 0.
  - Reset in the middle of a bus transaction aborts it: no rdy_ pulse, and no write commit.
- FSM states and transitions:
  - IDLE: a request is accepted when cs_=0 and as_=0 at the clk edge. addr, rw and wr_data are latched. Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - WAIT: the wait counter counts WAIT_CYCLES cycles, then moves to RESP.
  - RESP: rdy_=0 and rd_data = the latched register's value for exactly one cycle, then return to IDLE. Requests are not accepted in RESP.
  - Latency: rdy_ goes low WAIT_CYCLES+1 cycles after the accepting edge.
  - as_/cs_ activity outside IDLE is ignored; there is no queuing.
- Write commit: the latched write takes effect at the same edge that enters RESP.
  - Read data reflects the register value at RESP entry, including any same-cycle timer update.
- Timer (evaluated every cycle while start=1):
  - If COUNTER == EXPR: COUNTER ← 0, irq flag ← 1, and start ← 0 unless periodic=1.
  - Else: COUNTER ← COUNTER+1, wrapping at 2^CNT_W.
  - EXPR=0 with start=1: match every cycle; irq set on the first cycle.
- Collisions in the same cycle:
  - Bus write to COUNTER or CTRL beats the timer update.
  - Timer set of the irq flag beats a bus clear of INTR (no lost interrupt).
- irq output equals the INTR flag bit, registered; no extra latency.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - CTRL[15:8] holds an 8-bit prescale value PS, read/write.
  - A prescale counter makes the timer step (increment or match) once every PS+1 cycles.
  - The prescale counter resets to 0 on reset, on any CTRL write, and when start=0.
- Undefined:
  - CTRL[15:8] reads 0 and writes to it are ignored.
  - The timer steps every cycle; no prescale logic is synthesised.

Test Plan:
- Read after reset, WAIT_CYCLES=0: read offsets 0..3 → each returns 0x0; rdy_ low exactly 1 cycle after the accept edge; rd_data=0 on all other cycles.
- Wait states, WAIT_CYCLES=3: write EXPR=0x10, then read it back → rdy_ low on the 4th cycle after accept; read returns 0x10; as_ pulses during WAIT produce no second response.
- One-shot: EXPR=5, CTRL=0x1 → irq rises 6 steps after start; COUNTER=0 and CTRL.start=0 afterwards. Writing INTR=0 clears irq; writing INTR=1 leaves it unchanged.
- Periodic: EXPR=3, CTRL=0x3, clear irq after each set → irq set every 4 cycles; a clear written on the same edge as a match leaves irq=1.
- Collision and reset: a COUNTER write of 0x100 on the same edge as an increment gives 0x100. Asserting reset during WAIT gives rdy_=1, no write committed, and all registers 0.
- TIMER_PRESCALE_EN defined: CTRL=0x0301 (PS=3), EXPR=2 → irq after 12 cycles. Same stimulus without the macro → irq after 3 cycles, and CTRL reads 0x1.
